calc1_port_driver: RTL and testbench

- Request sequencer that sits directly upstream of one calc1 requester port; one instance per port, four per calc1.
- Accepts a complete operation (cmd, op1, op2) on a valid/ready interface and serialises it into calc1's two-cycle port protocol: cmd+op1 in one cycle, then cmd=0+op2 in the next.
- Waits for calc1's response, enforces a timeout, and returns resp/data on a buffered valid/ready response interface.

---
 rtl/calc1_port_driver.sv | 131 +++++++++++++
 tb/tb_calc1_port_driver.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: sequences one complete operation into calc1's two-cycle
// requester protocol, waits (with timeout) for the answer and presents it on
// a held valid/ready response interface. One outstanding transaction.
module calc1_port_driver #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 8
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [0:3]  req_cmd,
  input  logic [0:31] req_op1,
  input  logic [0:31] req_op2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [0:1]  rsp_resp,
  output logic [0:31] rsp_data,
  output logic        rsp_timeout,
  output logic [0:3]  calc_cmd_out,
  output logic [0:31] calc_data_out,
  input  logic [0:1]  calc_resp_in,
  input  logic [0:31] calc_data_in
);

  typedef enum logic [2:0] {IDLE, CMD, OP2, WAIT, HOLD} state_t;

  localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(TIMEOUT);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [0:31]        op2_q, op2_nxt;
  logic [0:3]         cmd_out_nxt;
  logic [0:31]        data_out_nxt;
  logic [0:1]         resp_nxt;
  logic [0:31]        rdata_nxt;
  logic               to_nxt;

  // Next-state and next-output computation; every register defaults to hold.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    op2_nxt      = op2_q;
    cmd_out_nxt  = calc_cmd_out;
    data_out_nxt = calc_data_out;
    resp_nxt     = rsp_resp;
    rdata_nxt    = rsp_data;
    to_nxt       = rsp_timeout;
    case (state)
      IDLE: begin
        if (req_valid) begin
          op2_nxt = req_op2;
          if (req_cmd != 4'd0) begin
            state_nxt    = CMD;
            cmd_out_nxt  = req_cmd;
            data_out_nxt = req_op1;
          end else begin
            // Null command: answer locally, calc1 never sees it.
            state_nxt = HOLD;
            resp_nxt  = 2'b10;
            rdata_nxt = 32'd0;
            to_nxt    = 1'b0;
          end
        end
      end
      CMD: begin
        state_nxt    = OP2;
        cmd_out_nxt  = 4'd0;
        data_out_nxt = op2_q;
      end
      OP2: begin
        state_nxt    = WAIT;
        cmd_out_nxt  = 4'd0;
        data_out_nxt = 32'd0;
        cnt_nxt      = '0;
      end
      WAIT: begin
        // A real calc1 answer takes priority over a coincident timeout.
        if (calc_resp_in != 2'd0) begin
          state_nxt = HOLD;
          resp_nxt  = calc_resp_in;
          rdata_nxt = calc_data_in;
          to_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if ((cnt + CNT_W'(1)) == TO_LIM) begin
            state_nxt = HOLD;
            resp_nxt  = 2'd0;
            rdata_nxt = 32'd0;
            to_nxt    = 1'b1;
          end
        end
      end
      HOLD: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and registered outputs; reset abandons any transaction.
  always_ff @(posedge c_clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_resp      <= 2'd0;
      rsp_data      <= 32'd0;
      rsp_timeout   <= 1'b0;
      calc_cmd_out  <= 4'd0;
      calc_data_out <= 32'd0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      req_ready     <= (state_nxt == IDLE);
      rsp_valid     <= (state_nxt == HOLD);
      rsp_resp      <= resp_nxt;
      rsp_data      <= rdata_nxt;
      rsp_timeout   <= to_nxt;
      calc_cmd_out  <= cmd_out_nxt;
      calc_data_out <= data_out_nxt;
    end
  end

  // Second operand is pure data and only read after being loaded.
  always_ff @(posedge c_clk) begin
    op2_q <= op2_nxt;
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Bench for calc1_port_driver: directed scenarios plus randomized transactions
// with a transaction-level reference for the calc1 bus and the response.
module tb_calc1_port_driver;

  localparam int TIMEOUT = 15;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [0:3]  req_cmd;
  logic [0:31] req_op1;
  logic [0:31] req_op2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [0:1]  rsp_resp;
  logic [0:31] rsp_data;
  logic        rsp_timeout;
  logic [0:3]  calc_cmd_out;
  logic [0:31] calc_data_out;
  logic [0:1]  calc_resp_in;
  logic [0:31] calc_data_in;

  int checks = 0;
  int errors = 0;

  calc1_port_driver #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .c_clk(c_clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_op1(req_op1), .req_op2(req_op2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
    .calc_cmd_out(calc_cmd_out), .calc_data_out(calc_data_out),
    .calc_resp_in(calc_resp_in), .calc_data_in(calc_data_in)
  );

  always #5 c_clk = ~c_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  // One full transaction. d = WAIT cycle on which calc1 answers (> TIMEOUT: never).
  task automatic txn(input logic [3:0] cmd, input logic [31:0] op1, input logic [31:0] op2,
                     input int d, input logic [1:0] code, input logic [31:0] rdata,
                     input int bp, input bit noise);
    int lat_exp;
    int lat;
    logic [1:0]  e_resp;
    logic [31:0] e_data;
    logic        e_to;
    // Reference: outcome and edges-after-accept until rsp_valid is seen.
    if (cmd == 4'd0) begin
      lat_exp = 0; e_resp = 2'b10; e_data = 32'd0; e_to = 1'b0;
    end else if (d <= TIMEOUT) begin
      lat_exp = 2 + d; e_resp = code; e_data = rdata; e_to = 1'b0;
    end else begin
      lat_exp = 2 + TIMEOUT; e_resp = 2'd0; e_data = 32'd0; e_to = 1'b1;
    end
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_cmd = cmd; req_op1 = op1; req_op2 = op2;
    tick();
    req_valid = 1'b0; req_cmd = 4'($urandom); req_op1 = $urandom; req_op2 = $urandom;
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      if (n == 0) begin
        chk("bus_cmd_c1", calc_cmd_out, cmd);
        chk("bus_data_c1", calc_data_out, (cmd != 0) ? op1 : 32'd0);
        chk("req_ready_busy", req_ready, 0);
      end
      if (cmd != 0 && n == 1) begin
        chk("bus_cmd_c2", calc_cmd_out, 0);
        chk("bus_data_c2", calc_data_out, op2);
      end
      if (cmd != 0 && n == 2) begin
        chk("bus_cmd_c3", calc_cmd_out, 0);
        chk("bus_data_c3", calc_data_out, 0);
      end
      if (rsp_valid) begin
        lat = n;
        break;
      end
      calc_data_in = $urandom;
      if (cmd != 0 && d <= TIMEOUT && n == 1 + d) begin
        calc_resp_in = code; calc_data_in = rdata;
      end else if (noise && n < 2) calc_resp_in = 2'd3;
      else calc_resp_in = 2'd0;
      tick();
    end
    calc_resp_in = 2'd0;
    chk("rsp_latency", lat, lat_exp);
    chk("rsp_resp", rsp_resp, e_resp);
    chk("rsp_data", rsp_data, e_data);
    chk("rsp_timeout", rsp_timeout, e_to);
    // Backpressure: response held, no new acceptance while a new op waits.
    rsp_ready = 1'b0;
    if (bp > 0) begin
      req_valid = 1'b1; req_cmd = 4'd1; req_op1 = $urandom; req_op2 = $urandom;
    end
    for (int i = 0; i < bp; i++) begin
      tick();
      chk("bp_valid", rsp_valid, 1);
      chk("bp_resp", rsp_resp, e_resp);
      chk("bp_data", rsp_data, e_data);
      chk("bp_timeout", rsp_timeout, e_to);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_no_issue", calc_cmd_out, 0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
    chk("post_hs_no_issue", calc_cmd_out, 0);
  endtask

  // Reset after 'edges' cycles past acceptance, then a stale calc1 answer.
  task automatic rst_mid(input int edges);
    req_valid = 1'b1; req_cmd = 4'd6; req_op1 = 32'hA5A5_0001; req_op2 = 32'h0000_0003;
    tick();
    req_valid = 1'b0;
    repeat (edges) tick();
    #2 reset = 1'b1;
    #1;
    chk("rst_cmd", calc_cmd_out, 0);
    chk("rst_data", calc_data_out, 0);
    chk("rst_valid", rsp_valid, 0);
    tick();
    reset = 1'b0;
    calc_resp_in = 2'd1; calc_data_in = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_late_valid", rsp_valid, 0);
      chk("rst_late_ready", req_ready, 1);
      chk("rst_late_cmd", calc_cmd_out, 0);
    end
    calc_resp_in = 2'd0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_cmd = 4'd0; req_op1 = 32'd0; req_op2 = 32'd0;
    rsp_ready = 1'b0; calc_resp_in = 2'd0; calc_data_in = 32'd0;
    #2;
    chk("reset_cmd", calc_cmd_out, 0);
    chk("reset_data", calc_data_out, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_resp", rsp_resp, 0);
    chk("reset_rdata", rsp_data, 0);
    chk("reset_timeout", rsp_timeout, 0);
    repeat (2) tick();
    reset = 1'b0;
    chk("reset_req_ready", req_ready, 1);

    txn(4'd1, 32'h1, 32'h1FFF_FFFF, 3, 2'd1, 32'h2000_0000, 0, 0);
    txn(4'd1, 32'hFFFF_FFFF, 32'h1, 2, 2'd2, 32'h0, 0, 0);
    txn(4'd2, 32'h1, 32'hF, 1, 2'd2, 32'h0, 0, 0);
    txn(4'd1, 32'h7, 32'h8, 99, 2'd1, 32'hF, 0, 0);
    txn(4'd1, 32'h7, 32'h8, 15, 2'd1, 32'hF, 0, 0);
    txn(4'd1, 32'h7, 32'h8, 14, 2'd3, 32'hDEAD_BEEF, 0, 1);
    txn(4'd5, 32'h3, 32'h2, 4, 2'd1, 32'hC, 5, 1);
    txn(4'd0, 32'h55, 32'h66, 1, 2'd1, 32'h1, 2, 0);
    rst_mid(0);
    rst_mid(6);

    for (int t = 0; t < 25; t++) begin
      txn(4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(1, 18)),
          2'($urandom_range(1, 3)), $urandom, int'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
